// File: rtl/imem_loader_pkg.sv
// ----------------------------------------------------------------------------
// imem_loader_pkg
//   Shared types and constants for the instruction-memory loader.
//   - loader_state_t : frame-parser state encoding
//   - LOADER_MAGIC   : start-of-frame byte
//   - LOADER_ACK/NAK : response bytes returned to the UART transmitter
// ----------------------------------------------------------------------------
package imem_loader_pkg;

   typedef enum logic [2:0] {
      IDLE,
      LEN_LO,
      LEN_HI,
      DATA,
      CSUM,
      RESP
   } loader_state_t;

   localparam logic [7:0] LOADER_MAGIC = 8'hA5;
   localparam logic [7:0] LOADER_ACK   = 8'h06;
   localparam logic [7:0] LOADER_NAK   = 8'h15;

endpackage

// File: rtl/imem_loader_byte_word_packer.sv
// ----------------------------------------------------------------------------
// byte_word_packer
//   Packs a byte stream into 32-bit little-endian words (first byte -> [7:0]).
//   When the 4th byte of a word is accepted on cycle t, word_valid is high for
//   exactly cycle t+1 with the assembled word on word_data.
// Ports:
//   clk, reset   : clock, asynchronous active-high reset
//   clear        : synchronous restart of the byte counter (discards partials)
//   byte_valid   : byte_data holds a byte to pack this cycle
//   byte_data    : incoming byte
//   byte_cnt     : number of bytes already held for the current word (0..3)
//   word_valid   : one-cycle pulse, word_data is a complete word
//   word_data    : last completed word
// ----------------------------------------------------------------------------
module byte_word_packer (
   input  logic        clk,
   input  logic        reset,
   input  logic        clear,
   input  logic        byte_valid,
   input  logic [7:0]  byte_data,
   output logic [1:0]  byte_cnt,
   output logic        word_valid,
   output logic [31:0] word_data
);

   logic [23:0] low_bytes;

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values; blocking here would create ordering races.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         byte_cnt   <= 2'd0;
         low_bytes  <= 24'd0;
         word_valid <= 1'b0;
         word_data  <= 32'd0;
      end else begin
         word_valid <= 1'b0;
         if (clear) begin
            byte_cnt <= 2'd0;
         end else if (byte_valid) begin
            if (byte_cnt == 2'd3) begin
               word_valid <= 1'b1;
               word_data  <= {byte_data, low_bytes};
            end else begin
               low_bytes[{byte_cnt, 3'b000} +: 8] <= byte_data;
            end
            byte_cnt <= byte_cnt + 2'd1;
         end
      end
   end

endmodule

// File: rtl/imem_loader.sv
// ----------------------------------------------------------------------------
// imem_loader
//   Writer side of the instruction memory. Parses a framed UART byte stream
//     A5 | LEN_LO | LEN_HI | 4*N data bytes (LSB first per word) | XOR csum
//   writes each word through the memory write port, holds the core in reset
//   while loading and answers with ACK (0x06) or NAK (0x15).
// Ports:
//   clk, reset          : clock, asynchronous active-high reset
//   rx_valid, rx_data   : received-byte strobe and byte
//   ack_valid, ack_data : pending response byte (held until ack_ready)
//   ack_ready           : transmitter accepts the response
//   mem_we, mem_addr,
//   mem_wdata           : instruction-memory write port
//   cpu_reset_n         : core reset, low while loading or after a failed load
//   busy                : a frame is in progress (state not IDLE)
//   error               : sticky failure of the last frame
// ----------------------------------------------------------------------------
module imem_loader
   import imem_loader_pkg::*;
#(
   parameter int ADDR_WIDTH     = 10,
   parameter int DATA_WIDTH     = 32,
   parameter int TIMEOUT_CYCLES = 1000000,
   parameter int HOLD_AT_RESET  = 1
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  rx_valid,
   input  logic [7:0]            rx_data,
   output logic                  ack_valid,
   output logic [7:0]            ack_data,
   input  logic                  ack_ready,
   output logic                  mem_we,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic [DATA_WIDTH-1:0] mem_wdata,
   output logic                  cpu_reset_n,
   output logic                  busy,
   output logic                  error
);

   localparam int                  TO_W      = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [TO_W-1:0]     TO_LAST   = TO_W'(TIMEOUT_CYCLES - 1);
   localparam logic [31:0]         MAX_WORDS = 32'd1 << ADDR_WIDTH;
   localparam logic [ADDR_WIDTH:0] ONE_WIDE  = (ADDR_WIDTH + 1)'(1);
   localparam logic                HOLD      = (HOLD_AT_RESET != 0);

   loader_state_t          state;
   logic [7:0]             len_lo;
   logic [7:0]             csum;
   logic [ADDR_WIDTH:0]    word_count;
   logic [ADDR_WIDTH-1:0]  word_idx;
   logic [TO_W-1:0]        idle_cnt;

   logic [1:0]             pk_byte_cnt;
   logic                   pk_word_valid;
   logic [31:0]            pk_word_data;

   logic [31:0]            n_words;
   logic                   len_ok;
   logic                   last_word;
   logic                   waiting;
   logic                   timed_out;

   // NOTE: every signal assigned in always_comb gets a default first, so no
   // path leaves it unassigned and no latch is inferred.
   always_comb begin
      n_words   = 32'd0;
      len_ok    = 1'b0;
      last_word = 1'b0;
      waiting   = 1'b0;
      timed_out = 1'b0;

      n_words   = {16'd0, rx_data, len_lo};
      len_ok    = (n_words != 32'd0) && (n_words <= MAX_WORDS);
      last_word = ({1'b0, word_idx} == (word_count - ONE_WIDE));
      waiting   = (state inside {LEN_LO, LEN_HI, DATA, CSUM});
      // A byte arriving on the expiry cycle wins over the timeout.
      timed_out = waiting && !rx_valid && (idle_cnt == TO_LAST);
   end

   byte_word_packer u_packer (
      .clk        (clk),
      .reset      (reset),
      .clear      (state != DATA),
      .byte_valid (rx_valid && (state == DATA)),
      .byte_data  (rx_data),
      .byte_cnt   (pk_byte_cnt),
      .word_valid (pk_word_valid),
      .word_data  (pk_word_data)
   );

   assign mem_we    = pk_word_valid;
   assign mem_wdata = pk_word_data;
   assign mem_addr  = word_idx;
   assign busy      = (state != IDLE);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state       <= IDLE;
         len_lo      <= 8'd0;
         csum        <= 8'd0;
         word_count  <= '0;
         word_idx    <= '0;
         idle_cnt    <= '0;
         ack_valid   <= 1'b0;
         ack_data    <= 8'h00;
         error       <= 1'b0;
         cpu_reset_n <= !HOLD;
      end else begin
         if (rx_valid || !waiting) idle_cnt <= '0;
         else                      idle_cnt <= idle_cnt + TO_W'(1);

         // Index advances on the write cycle, so mem_addr names the word
         // being written while mem_we is high.
         if (pk_word_valid) word_idx <= word_idx + ADDR_WIDTH'(1);

         case (state)
            IDLE: begin
               if (rx_valid && rx_data == LOADER_MAGIC) begin
                  state       <= LEN_LO;
                  cpu_reset_n <= 1'b0;
                  error       <= 1'b0;
                  word_idx    <= '0;
                  csum        <= 8'd0;
               end
            end
            LEN_LO: begin
               if (rx_valid) begin
                  len_lo <= rx_data;
                  state  <= LEN_HI;
               end
            end
            LEN_HI: begin
               if (rx_valid) begin
                  if (len_ok) begin
                     word_count <= n_words[ADDR_WIDTH:0];
                     state      <= DATA;
                  end else begin
                     state     <= RESP;
                     ack_valid <= 1'b1;
                     ack_data  <= LOADER_NAK;
                     error     <= 1'b1;
                  end
               end
            end
            DATA: begin
               if (rx_valid) begin
                  csum <= csum ^ rx_data;
                  if (pk_byte_cnt == 2'd3 && last_word) state <= CSUM;
               end
            end
            CSUM: begin
               if (rx_valid) begin
                  state     <= RESP;
                  ack_valid <= 1'b1;
                  if (rx_data == csum) begin
                     ack_data <= LOADER_ACK;
                  end else begin
                     ack_data <= LOADER_NAK;
                     error    <= 1'b1;
                  end
               end
            end
            RESP: begin
               if (ack_valid && ack_ready) begin
                  ack_valid <= 1'b0;
                  state     <= IDLE;
                  if (ack_data == LOADER_ACK) cpu_reset_n <= 1'b1;
               end
            end
            default: state <= IDLE;
         endcase

         if (timed_out) begin
            state     <= RESP;
            ack_valid <= 1'b1;
            ack_data  <= LOADER_NAK;
            error     <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_imem_loader.sv
// ----------------------------------------------------------------------------
// tb_imem_loader
//   Scoreboard bench: expected memory writes and response bytes are queued as
//   frames are driven and compared when the loader produces them.
// ----------------------------------------------------------------------------
module tb_imem_loader;

   localparam int AW = 10;
   localparam int TO = 64;
   localparam logic [7:0] ACK = 8'h06;
   localparam logic [7:0] NAK = 8'h15;

   logic          clk = 1'b0;
   logic          reset;
   logic          rx_valid;
   logic [7:0]    rx_data;
   logic          ack_valid;
   logic [7:0]    ack_data;
   logic          ack_ready;
   logic          mem_we;
   logic [AW-1:0] mem_addr;
   logic [31:0]   mem_wdata;
   logic          cpu_reset_n;
   logic          busy;
   logic          error;

   imem_loader #(
      .ADDR_WIDTH     (AW),
      .DATA_WIDTH     (32),
      .TIMEOUT_CYCLES (TO),
      .HOLD_AT_RESET  (1)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .rx_valid    (rx_valid),
      .rx_data     (rx_data),
      .ack_valid   (ack_valid),
      .ack_data    (ack_data),
      .ack_ready   (ack_ready),
      .mem_we      (mem_we),
      .mem_addr    (mem_addr),
      .mem_wdata   (mem_wdata),
      .cpu_reset_n (cpu_reset_n),
      .busy        (busy),
      .error       (error)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [AW-1:0] addr;
      logic [31:0]   data;
   } wr_t;

   int            vectors     = 0;
   int            miscompares = 0;
   wr_t           exp_wr[$];
   logic [7:0]    exp_resp[$];
   logic [31:0]   frame_words[$];
   int            wr_count    = 0;
   logic [AW-1:0] last_wr_addr = '0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // Write monitor: every mem_we pulse must match the head of the queue.
   initial begin
      wr_t e;
      forever begin
         @(negedge clk);
         if (mem_we === 1'b1) begin
            wr_count++;
            last_wr_addr = mem_addr;
            if (exp_wr.size() == 0) begin
               check("wr_spurious", 32'(mem_we), 32'd0);
            end else begin
               e = exp_wr.pop_front();
               check("wr_addr", 32'(mem_addr), 32'(e.addr));
               check("wr_data", mem_wdata, e.data);
            end
         end
      end
   end

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation did not finish, time %0t", $time);
      $fatal(1, "watchdog");
   end

   task automatic send_byte(input logic [7:0] b);
      @(negedge clk);
      rx_valid = 1'b1;
      rx_data  = b;
      @(negedge clk);
      rx_valid = 1'b0;
   endtask

   // Sends the words in frame_words as one frame; bad=1 replaces the checksum.
   task automatic send_frame(input bit bad, input logic [7:0] bad_csum);
      int         n;
      logic [7:0] cs;
      logic [7:0] b;
      n  = frame_words.size();
      cs = 8'd0;
      send_byte(8'hA5);
      send_byte(n[7:0]);
      send_byte(n[15:8]);
      for (int w = 0; w < n; w++) begin
         exp_wr.push_back('{addr: AW'(w), data: frame_words[w]});
         for (int k = 0; k < 4; k++) begin
            b  = frame_words[w][8*k +: 8];
            cs = cs ^ b;
            send_byte(b);
         end
         check("we_latency", 32'(mem_we), 32'd1);
      end
      send_byte(bad ? bad_csum : cs);
      exp_resp.push_back(bad ? NAK : ACK);
   endtask

   // Waits for the response, holds ack_ready low for 'hold' cycles, then
   // completes the handshake and checks the post-handshake state.
   task automatic expect_resp(input int hold, input int bound);
      int         t;
      logic [7:0] exp;
      t = 0;
      while (ack_valid !== 1'b1 && t < bound) begin
         @(negedge clk);
         t++;
      end
      if (ack_valid !== 1'b1) begin
         check("ack_timeout", 32'(ack_valid), 32'd1);
         if (exp_resp.size() != 0) void'(exp_resp.pop_front());
         return;
      end
      exp = (exp_resp.size() != 0) ? exp_resp.pop_front() : 8'hXX;
      check("ack_data", 32'(ack_data), 32'(exp));
      check("error", 32'(error), 32'(exp == NAK));
      check("cpu_held", 32'(cpu_reset_n), 32'd0);
      check("busy_resp", 32'(busy), 32'd1);
      repeat (hold) begin
         @(negedge clk);
         check("ack_hold", 32'(ack_valid), 32'd1);
         check("ack_stable", 32'(ack_data), 32'(exp));
      end
      ack_ready = 1'b1;
      @(negedge clk);
      ack_ready = 1'b0;
      check("ack_done", 32'(ack_valid), 32'd0);
      check("cpu_reset_n", 32'(cpu_reset_n), 32'(exp == ACK));
      check("busy_idle", 32'(busy), 32'd0);
   endtask

   task automatic check_reset_state();
      check("rst_mem_we", 32'(mem_we), 32'd0);
      check("rst_mem_addr", 32'(mem_addr), 32'd0);
      check("rst_mem_wdata", mem_wdata, 32'd0);
      check("rst_ack_valid", 32'(ack_valid), 32'd0);
      check("rst_ack_data", 32'(ack_data), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_error", 32'(error), 32'd0);
      check("rst_cpu_reset_n", 32'(cpu_reset_n), 32'd0);
   endtask

   initial begin
      int wr_before;
      reset     = 1'b0;
      rx_valid  = 1'b0;
      rx_data   = 8'h00;
      ack_ready = 1'b0;
      #2 reset = 1'b1;
      repeat (3) @(negedge clk);
      check_reset_state();
      reset = 1'b0;

      // ack_ready with no pending response has no effect
      ack_ready = 1'b1;
      @(negedge clk);
      ack_ready = 1'b0;
      check("stray_ready", 32'(ack_valid), 32'd0);

      // Single-word load
      frame_words = '{32'h00000013};
      send_frame(1'b0, 8'h00);
      expect_resp(0, 50);

      // Three-word load, ack_ready delayed 5 cycles
      frame_words = '{32'h00500093, 32'h00A00113, 32'h002081B3};
      send_frame(1'b0, 8'h00);
      expect_resp(5, 50);

      // Bad checksum: word still written, then NAK
      frame_words = '{32'hDEADBEEF};
      send_frame(1'b1, 8'h00);
      expect_resp(0, 50);

      // N = 0: start byte clears sticky error, then NAK with no write
      wr_before = wr_count;
      send_byte(8'hA5);
      check("err_cleared", 32'(error), 32'd0);
      send_byte(8'h00);
      send_byte(8'h00);
      exp_resp.push_back(NAK);
      expect_resp(0, 50);

      // N = 0x0401 exceeds memory
      send_byte(8'hA5);
      send_byte(8'h01);
      send_byte(8'h04);
      exp_resp.push_back(NAK);
      expect_resp(0, 50);
      check("len_nak_no_wr", 32'(wr_count), 32'(wr_before));

      // N = 0x0400 fills memory
      frame_words.delete();
      for (int i = 0; i < 1024; i++) frame_words.push_back($urandom());
      send_frame(1'b0, 8'h00);
      expect_resp(0, 50);
      check("last_addr", 32'(last_wr_addr), 32'h3FF);

      // Noise in IDLE, then a frame that stalls mid-word
      send_byte(8'h00);
      send_byte(8'hFF);
      check("noise_idle", 32'(busy), 32'd0);
      wr_before = wr_count;
      send_byte(8'hA5);
      send_byte(8'h01);
      send_byte(8'h00);
      send_byte(8'h11);
      send_byte(8'h22);
      exp_resp.push_back(NAK);
      expect_resp(0, TO + 20);
      check("timeout_no_wr", 32'(wr_count), 32'(wr_before));

      // Reset after two data bytes, then a clean load
      send_byte(8'hA5);
      send_byte(8'h01);
      send_byte(8'h00);
      send_byte(8'h11);
      send_byte(8'h22);
      @(negedge clk);
      reset = 1'b1;
      #1;
      check_reset_state();
      @(negedge clk);
      reset = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_no_wr", 32'(wr_count), 32'(wr_before));
      frame_words = '{32'h12345678};
      send_frame(1'b0, 8'h00);
      expect_resp(0, 50);

      repeat (3) @(negedge clk);
      check("wr_pending", 32'(exp_wr.size()), 32'd0);
      check("resp_pending", 32'(exp_resp.size()), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
